// File: rtl/mux_scan_serializer.sv
// Registered N-lane mux: DIRECT registers a[sel] every cycle (1-cycle latency); SCAN snapshots
// all lanes and serializes lane 0..N-1 over valid/ready, holding out/out_idx stable while out_ready is low.
module mux_scan_serializer #(
   parameter int WLOG = 3,
   parameter int DW   = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [(1 << WLOG)*DW-1:0]   a,
   input  logic [WLOG-1:0]             sel,
   input  logic                        mode,
   input  logic                        start,
   input  logic                        out_ready,
   output logic [DW-1:0]               out,
   output logic [DW-1:0]               out_neg,
   output logic                        out_valid,
   output logic [WLOG-1:0]             out_idx,
   output logic                        busy,
   output logic                        done
);

   localparam int N = 1 << WLOG;
   localparam logic [WLOG-1:0] LAST_IDX = WLOG'(N - 1);
   localparam logic [WLOG-1:0] IDX_ONE  = WLOG'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   generate
      if (WLOG < 1 || WLOG > 6) begin : g_bad_wlog
         $error("mux_scan_serializer: WLOG must be within 1..6");
      end
      if (DW < 1) begin : g_bad_dw
         $error("mux_scan_serializer: DW must be at least 1");
      end
   endgenerate

   logic [1:0]          state_q,     state_d;
   logic [N*DW-1:0]     shadow_q,    shadow_d;
   logic [DW-1:0]       out_q,       out_d;
   logic [WLOG-1:0]     out_idx_q,   out_idx_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;

   // Lane views of the live input and of the snapshot, indexed directly by a WLOG-bit select.
   logic [DW-1:0]       a_lane      [N];
   logic [DW-1:0]       shadow_lane [N];

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_lanes
         assign a_lane[g]      = a[g*DW +: DW];
         assign shadow_lane[g] = shadow_q[g*DW +: DW];
      end
   endgenerate

   logic [WLOG-1:0]     idx_inc;
   logic                beat_xfer;

   assign idx_inc   = out_idx_q + IDX_ONE;
   assign beat_xfer = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      out_d       = out_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!mode) begin
               out_d       = a_lane[sel];
               out_idx_d   = sel;
               out_valid_d = 1'b1;
            end else if (start) begin
               shadow_d    = a;
               out_d       = a_lane[0];
               out_idx_d   = '0;
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = ST_SCAN;
            end else begin
               out_valid_d = 1'b0;
            end
         end

         ST_SCAN: begin
            // Only the snapshot feeds the output here; a/sel/mode/start are deliberately ignored.
            if (beat_xfer) begin
               if (out_idx_q == LAST_IDX) begin
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  out_idx_d = idx_inc;
                  out_d     = shadow_lane[idx_inc];
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         out_q       <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         out_q       <= out_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign out       = out_q;
   assign out_neg   = ~out_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;

   a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
      (busy_q && out_valid_q && !out_ready) |=> ($stable(out_q) && $stable(out_idx_q) && out_valid_q));

   a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
      done_q |-> !busy_q);

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer (WLOG=3, DW=4, lane i = i): stimulus pushes expected beats,
// a monitor pops one per accepted beat (out_valid && out_ready) and compares.
module tb_mux_scan_serializer;

   localparam int WLOG = 3;
   localparam int DW   = 4;
   localparam logic [31:0] A_PAT = 32'h7654_3210;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   a;
   logic [2:0]    sel;
   logic          mode;
   logic          start;
   logic          out_ready;
   logic [3:0]    out;
   logic [3:0]    out_neg;
   logic          out_valid;
   logic [2:0]    out_idx;
   logic          busy;
   logic          done;

   mux_scan_serializer #(.WLOG(WLOG), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .sel       (sel),
      .mode      (mode),
      .start     (start),
      .out_ready (out_ready),
      .out       (out),
      .out_neg   (out_neg),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] d;
      logic [2:0] i;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_lane(input int lane);
      beat_t b;
      b.d = 4'(lane);
      b.i = 3'(lane);
      exp_q.push_back(b);
   endtask

   task automatic push_scan();
      for (int l = 0; l < 8; l++) push_lane(l);
   endtask

   // Counts edges until done is seen; busy must stay high on every edge before it.
   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         cycles++;
         if (done === 1'b1) return;
         chk("busy_in_scan", {31'b0, busy}, 32'd1);
      end
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cycles);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got out=%0h idx=%0d expected no beat", out, out_idx);
         end else begin
            beat_t      e;
            logic [3:0] nd;
            e  = exp_q.pop_front();
            nd = ~e.d;
            chk("beat_data", {28'b0, out}, {28'b0, e.d});
            chk("beat_idx",  {29'b0, out_idx}, {29'b0, e.i});
            chk("beat_neg",  {28'b0, out_neg}, {28'b0, nd});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; a = A_PAT; sel = '0; mode = 1'b0; start = 1'b0; out_ready = 1'b0;
      repeat (2) cyc();
      chk("rst_out",   {28'b0, out},     32'h0);
      chk("rst_neg",   {28'b0, out_neg}, 32'hF);
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_idx",   {29'b0, out_idx}, 32'h0);
      chk("rst_busy",  {31'b0, busy},    32'h0);
      chk("rst_done",  {31'b0, done},    32'h0);
      rst_n = 1'b1;

      // DIRECT
      out_ready = 1'b1; mode = 1'b0;
      sel = 3'd3; push_lane(3); cyc();
      chk("direct_out3",   {28'b0, out},     32'h3);
      chk("direct_neg3",   {28'b0, out_neg}, 32'hC);
      chk("direct_idx3",   {29'b0, out_idx}, 32'h3);
      chk("direct_valid",  {31'b0, out_valid}, 32'h1);
      sel = 3'd7; push_lane(7); cyc();
      chk("direct_out7",   {28'b0, out},     32'h7);
      sel = 3'd0; push_lane(0); cyc();
      sel = 3'd5; push_lane(5); cyc();
      chk("direct_out5",   {28'b0, out},     32'h5);

      // mode 0->1 without start: valid drops, out/idx hold
      mode = 1'b1; cyc();
      chk("m1_valid",    {31'b0, out_valid}, 32'h0);
      chk("m1_hold_out", {28'b0, out},       32'h5);
      chk("m1_hold_idx", {29'b0, out_idx},   32'h5);

      // asynchronous reset mid-run, visible before the next edge
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out",   {28'b0, out},     32'h0);
      chk("arst_neg",   {28'b0, out_neg}, 32'hF);
      chk("arst_valid", {31'b0, out_valid}, 32'h0);
      chk("arst_busy",  {31'b0, busy},    32'h0);
      cyc();
      rst_n = 1'b1;

      // SCAN, free-running consumer
      start = 1'b1; push_scan(); cyc(); start = 1'b0;
      chk("scan_first_out", {28'b0, out},  32'h0);
      chk("scan_busy",      {31'b0, busy}, 32'h1);
      chk("scan_valid",     {31'b0, out_valid}, 32'h1);
      wait_done(n);
      chk("scan_len",        n, 32'd8);
      chk("scan_busy_done",  {31'b0, busy},      32'h0);
      chk("scan_valid_done", {31'b0, out_valid}, 32'h0);
      cyc();
      chk("done_width", {31'b0, done}, 32'h0);

      // backpressure at idx 2, input changed mid-scan
      start = 1'b1; push_scan(); cyc(); start = 1'b0;
      cyc(); cyc();
      chk("bp_idx", {29'b0, out_idx}, 32'h2);
      out_ready = 1'b0; a = 32'hFFFF_FFFF;
      repeat (3) begin
         cyc();
         chk("bp_hold_out",   {28'b0, out},       32'h2);
         chk("bp_hold_valid", {31'b0, out_valid}, 32'h1);
         chk("bp_hold_idx",   {29'b0, out_idx},   32'h2);
      end
      out_ready = 1'b1;
      wait_done(n);
      chk("bp_tail_len", n, 32'd6);
      a = A_PAT; cyc();

      // start/mode/sel changes during SCAN and start during DONE are ignored
      start = 1'b1; push_scan(); cyc();
      mode = 1'b0; sel = 3'd6;
      chk("ign_first_out", {28'b0, out}, 32'h0);
      wait_done(n);
      chk("ign_len", n, 32'd8);
      mode = 1'b1; cyc(); start = 1'b0;
      chk("done_start_busy",  {31'b0, busy},      32'h0);
      chk("done_start_valid", {31'b0, out_valid}, 32'h0);
      cyc();
      chk("idle_no_restart_busy",  {31'b0, busy},      32'h0);
      chk("idle_no_restart_valid", {31'b0, out_valid}, 32'h0);

      // reset mid-scan at idx 5
      start = 1'b1; push_scan(); cyc(); start = 1'b0;
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 20; k++) begin
            if (out_idx === 3'd5) begin
               seen = 1'b1;
               break;
            end
            cyc();
         end
         chk("rs_reach_idx5", {31'b0, seen}, 32'h1);
      end
      rst_n = 1'b0;
      #1;
      chk("rs_out",   {28'b0, out},       32'h0);
      chk("rs_idx",   {29'b0, out_idx},   32'h0);
      chk("rs_valid", {31'b0, out_valid}, 32'h0);
      chk("rs_busy",  {31'b0, busy},      32'h0);
      chk("rs_done",  {31'b0, done},      32'h0);
      exp_q.delete();
      repeat (2) cyc();
      chk("rs_no_done", {31'b0, done}, 32'h0);
      rst_n = 1'b1;
      start = 1'b1; push_scan(); cyc(); start = 1'b0;
      chk("rs2_idx",  {29'b0, out_idx}, 32'h0);
      chk("rs2_busy", {31'b0, busy},    32'h1);
      wait_done(n);
      chk("rs2_len", n, 32'd8);
      cyc();

      // mode 1->0: DIRECT resumes on the next edge
      mode = 1'b0; sel = 3'd4; push_lane(4); cyc();
      chk("resume_out",   {28'b0, out},       32'h4);
      chk("resume_valid", {31'b0, out_valid}, 32'h1);
      mode = 1'b1; cyc();
      chk("resume_drop", {31'b0, out_valid}, 32'h0);
      cyc();
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
